// File: rtl/sram_bus_arbiter.sv
// Two-port (inst/data) to single SRAM-like port arbiter with an in-order owner FIFO.
// Optional macro ARB_RR_EN selects round-robin unlocked grant; default is D-over-I priority.
//
// state     | meaning
// ST_OPEN   | no presented request waiting; grant follows the priority rule
// ST_LOCKED | a request is presented but not yet accepted; grant frozen to lock_owner_q
module sram_bus_arbiter #(
    parameter int MAX_OUTST = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_wstrb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [3:0]        s_wstrb,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy
);
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;

    typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;

    lock_state_e          state_q;
    logic                 lock_owner_q;
    logic [MAX_OUTST-1:0] owner_q;
    logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]        count_q, count_d;
`ifdef ARB_RR_EN
    logic                 rr_last_q;
`endif

    logic full, gnt_d_sel, req_w, accept, pop, head;

    // gnt_d_sel: 1 selects port D, 0 selects port I
    always_comb begin
        gnt_d_sel = 1'b1;
        if (state_q == ST_LOCKED)
            gnt_d_sel = lock_owner_q;
`ifdef ARB_RR_EN
        else if (d_req && i_req)
            gnt_d_sel = ~rr_last_q;
`endif
        else
            gnt_d_sel = d_req;
    end

    // Full blocks purely on registered count so s_req never depends on s_data_ok.
    assign full    = (count_q == CW'(MAX_OUTST));
    assign req_w   = resetn & ~full & (gnt_d_sel ? d_req : i_req);
    assign accept  = req_w & s_addr_ok;
    assign head    = owner_q[rd_ptr_q];
    assign pop     = resetn & s_data_ok & (count_q != '0);
    assign count_d = count_q + CW'(accept) - CW'(pop);

    assign s_req   = req_w;
    assign s_wr    = req_w & gnt_d_sel & d_wr;
    assign s_size  = !req_w ? 2'd0 : (gnt_d_sel ? d_size : 2'd2);
    assign s_wstrb = (req_w && gnt_d_sel) ? d_wstrb : 4'd0;
    assign s_addr  = !req_w ? '0 : (gnt_d_sel ? d_addr : i_addr);
    assign s_wdata = (req_w && gnt_d_sel) ? d_wdata : '0;

    assign i_addr_ok = accept & ~gnt_d_sel;
    assign d_addr_ok = accept & gnt_d_sel;
    assign i_data_ok = pop & ~head;
    assign d_data_ok = pop & head;
    assign i_rdata   = i_data_ok ? s_rdata : '0;
    assign d_rdata   = d_data_ok ? s_rdata : '0;
    assign busy      = resetn & ((count_q != '0) | (state_q == ST_LOCKED));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_OPEN;
            lock_owner_q <= 1'b0;
        end else begin
            case (state_q)
                ST_OPEN: if (req_w && !s_addr_ok) begin
                    state_q      <= ST_LOCKED;
                    lock_owner_q <= gnt_d_sel;
                end
                ST_LOCKED: if (accept) state_q <= ST_OPEN;
                default: state_q <= ST_OPEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                owner_q[wr_ptr_q] <= gnt_d_sel;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     rr_last_q <= 1'b1;
        else if (accept) rr_last_q <= gnt_d_sel;
    end
`endif
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_sram_bus_arbiter;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int MAXO = 4;

    logic        clk, resetn;
    logic        i_req, i_addr_ok, i_data_ok;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_addr_ok, d_data_ok;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        busy;

    sram_bus_arbiter #(.MAX_OUTST(MAXO), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit mq[$];
    bit m_lock;
    int m_lock_own;
    bit m_rr_last;
    bit e_iok, e_dok, e_idok, e_ddok, e_sreq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_size = 0; d_wstrb = 0;
        d_addr = 0; d_wdata = 0; s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
    endtask

    task automatic do_reset(input bit check);
        resetn = 1'b0;
        i_req = 1; d_req = 1; i_addr = 32'h1c00_0000; d_addr = 32'h100;
        s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'h1234;
        #2;
        if (check) begin
            chk("rst_s_req", s_req, 0);
            chk("rst_i_addr_ok", i_addr_ok, 0);
            chk("rst_d_addr_ok", d_addr_ok, 0);
            chk("rst_busy", busy, 0);
            chk("rst_data_ok", {i_data_ok, d_data_ok}, 0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        clear_inputs();
        mq.delete(); m_lock = 0; m_lock_own = 0; m_rr_last = 1;
    endtask

    // One cycle: compare all outputs with the model, then advance the model.
    task automatic step();
        int g;
        logic [31:0] exp_addr;
        #2;
        if (mq.size() >= MAXO)             g = -1;
        else if (m_lock)                   g = m_lock_own;
        else if (d_req && i_req)           g = (RR && m_rr_last) ? 0 : 1;
        else if (d_req)                    g = 1;
        else if (i_req)                    g = 0;
        else                               g = -1;
        e_sreq = (g == 1) ? d_req : (g == 0) ? i_req : 1'b0;
        e_iok  = e_sreq && s_addr_ok && (g == 0);
        e_dok  = e_sreq && s_addr_ok && (g == 1);
        e_idok = s_data_ok && (mq.size() > 0) && (mq[0] == 1'b0);
        e_ddok = s_data_ok && (mq.size() > 0) && (mq[0] == 1'b1);
        exp_addr = !e_sreq ? 32'h0 : (g == 1) ? d_addr : i_addr;
        chk("s_req", s_req, e_sreq);
        chk("s_addr", s_addr, exp_addr);
        chk("s_wr", s_wr, (e_sreq && g == 1) ? d_wr : 1'b0);
        chk("s_size", s_size, !e_sreq ? 2'd0 : (g == 1) ? d_size : 2'd2);
        chk("s_wstrb", s_wstrb, (e_sreq && g == 1) ? d_wstrb : 4'd0);
        chk("s_wdata", s_wdata, (e_sreq && g == 1) ? d_wdata : 32'h0);
        chk("i_addr_ok", i_addr_ok, e_iok);
        chk("d_addr_ok", d_addr_ok, e_dok);
        chk("i_data_ok", i_data_ok, e_idok);
        chk("d_data_ok", d_data_ok, e_ddok);
        chk("i_rdata", i_rdata, e_idok ? s_rdata : 32'h0);
        chk("d_rdata", d_rdata, e_ddok ? s_rdata : 32'h0);
        chk("busy", busy, (mq.size() != 0) || m_lock);
        if (s_data_ok && mq.size() > 0) void'(mq.pop_front());
        if (e_iok || e_dok) begin
            mq.push_back(g == 1);
            m_lock = 0;
            m_rr_last = (g == 1);
        end else if (e_sreq) begin
            m_lock = 1;
            m_lock_own = g;
        end
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req, d_wr;
        logic [1:0]  d_size;
        logic [3:0]  d_wstrb;
        logic [31:0] d_addr, d_wdata;
        logic        s_aok, s_dok;
        logic [31:0] s_rdata;
        logic        e_sreq;
        logic [31:0] e_saddr;
        logic        e_swr, e_iok, e_dok, e_idok, e_ddok;
        logic [31:0] e_irdata, e_drdata;
        logic        e_busy;
    } vec_t;

    vec_t tbl[7];
    int acc;

    initial begin
        resetn = 1'b0;
        clear_inputs();
        // ireq iaddr        dreq wr sz wstrb daddr  dwdata aok dok rdata     | sreq saddr       swr iok dok idok ddok irdata   drdata   busy
        tbl[0] = '{1, 32'h1c00_0000, 0, 0, 0, 4'h0, 32'h0,   32'h0,  1, 0, 32'h0,    1, 32'h1c00_0000, 0, 1, 0, 0, 0, 32'h0,    32'h0,    0};
        tbl[1] = '{0, 32'h0,         1, 1, 2, 4'hf, 32'h100, 32'h55, 0, 1, 32'hAAAA, 1, 32'h100,       1, 0, 0, 1, 0, 32'hAAAA, 32'h0,    1};
        tbl[2] = '{1, 32'h2000,      1, 1, 2, 4'hf, 32'h100, 32'h55, 0, 0, 32'h0,    1, 32'h100,       1, 0, 0, 0, 0, 32'h0,    32'h0,    1};
        tbl[3] = '{1, 32'h2000,      1, 1, 2, 4'hf, 32'h100, 32'h55, 1, 0, 32'h0,    1, 32'h100,       1, 0, 1, 0, 0, 32'h0,    32'h0,    1};
        tbl[4] = '{1, 32'h2000,      0, 0, 0, 4'h0, 32'h0,   32'h0,  1, 1, 32'hBBBB, 1, 32'h2000,      0, 1, 0, 0, 1, 32'h0,    32'hBBBB, 1};
        tbl[5] = '{0, 32'h0,         0, 0, 0, 4'h0, 32'h0,   32'h0,  0, 1, 32'hCCCC, 0, 32'h0,         0, 0, 0, 1, 0, 32'hCCCC, 32'h0,    1};
        tbl[6] = '{0, 32'h0,         0, 0, 0, 4'h0, 32'h0,   32'h0,  0, 1, 32'hDDDD, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,    32'h0,    0};

        #3;
        do_reset(1);

        for (int k = 0; k < 7; k++) begin
            i_req = tbl[k].i_req; i_addr = tbl[k].i_addr; d_req = tbl[k].d_req; d_wr = tbl[k].d_wr;
            d_size = tbl[k].d_size; d_wstrb = tbl[k].d_wstrb; d_addr = tbl[k].d_addr;
            d_wdata = tbl[k].d_wdata; s_addr_ok = tbl[k].s_aok; s_data_ok = tbl[k].s_dok;
            s_rdata = tbl[k].s_rdata;
            #2;
            chk($sformatf("v%0d_s_req", k), s_req, tbl[k].e_sreq);
            chk($sformatf("v%0d_s_addr", k), s_addr, tbl[k].e_saddr);
            chk($sformatf("v%0d_s_wr", k), s_wr, tbl[k].e_swr);
            chk($sformatf("v%0d_i_addr_ok", k), i_addr_ok, tbl[k].e_iok);
            chk($sformatf("v%0d_d_addr_ok", k), d_addr_ok, tbl[k].e_dok);
            chk($sformatf("v%0d_i_data_ok", k), i_data_ok, tbl[k].e_idok);
            chk($sformatf("v%0d_d_data_ok", k), d_data_ok, tbl[k].e_ddok);
            chk($sformatf("v%0d_i_rdata", k), i_rdata, tbl[k].e_irdata);
            chk($sformatf("v%0d_d_rdata", k), d_rdata, tbl[k].e_drdata);
            chk($sformatf("v%0d_busy", k), busy, tbl[k].e_busy);
            @(posedge clk); #1;
        end

        // Both requesting with memory always ready: priority or alternation.
        do_reset(0);
        i_req = 1; i_addr = 32'h1c00_0040; d_req = 1; d_addr = 32'h200; d_size = 2;
        s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'h77;
        for (int k = 0; k < 6; k++) begin
            #2;
            chk($sformatf("both_d_win_%0d", k), d_addr_ok, RR ? ((k % 2) == 1) : 1'b1);
            step();
        end
        d_req = 0;
        #2;
        chk("both_i_after_d_drop", i_addr_ok, 1);
        step();

        // FIFO full: exactly MAXO accepts, full blocks even with a same-cycle pop.
        do_reset(0);
        i_req = 1; i_addr = 32'h1c00_0080; d_req = 1; d_addr = 32'h300; d_size = 2;
        s_addr_ok = 1; s_data_ok = 0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (e_iok || e_dok) acc++;
        end
        n_cmp++;
        if (acc != MAXO) begin
            n_err++;
            $display("FAIL full_accepts: got %0d expected %0d", acc, MAXO);
        end
        s_data_ok = 1; s_rdata = 32'h99;
        #2;
        chk("full_blocks_with_pop", s_req, 0);
        step();
        s_data_ok = 0;
        #2;
        chk("full_resume", s_req, 1);
        chk("full_resume_ok", i_addr_ok | d_addr_ok, 1);
        step();

        // Lock: D presented but unaccepted keeps the port while I raises.
        do_reset(0);
        d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h400; s_addr_ok = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin i_req = 1; i_addr = 32'h1c00_0100; end
            #2;
            chk($sformatf("lock_addr_%0d", k), s_addr, 32'h400);
            step();
        end
        s_addr_ok = 1;
        #2;
        chk("lock_accept_d", d_addr_ok, 1);
        step();
        d_req = 0;
        #2;
        chk("lock_then_i", i_addr_ok, 1);
        step();

        // Randomized traffic against the model.
        do_reset(0);
        for (int k = 0; k < 3000; k++) begin
            s_addr_ok = $urandom_range(0, 1);
            s_data_ok = ($urandom_range(0, 2) == 0);
            s_rdata   = $urandom;
            step();
            if (e_iok || !i_req) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = $urandom;
            end
            if (e_dok || !d_req) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_wr    = $urandom_range(0, 1);
                d_size  = 2'($urandom_range(0, 2));
                d_wstrb = 4'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
